// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: reads program words from synchronous memory, hands each
// instruction to the control unit with a Run pulse and waits for Done before advancing.
module instr_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic              Halt,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [8:0]        MemData,
  output logic [8:0]        IR,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Error
);

  localparam int               CNT_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_LOAD_IMM,
    S_ISSUE,
    S_WAIT_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic               halt_pending;
  logic [CNT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]  next_pc;
  logic               halt_now;

  // mvi occupies two words, so it advances the PC past its immediate.
  assign next_pc  = (IR[8:6] == OP_MVI) ? PC + ADDR_W'(2) : PC + ADDR_W'(1);
  assign halt_now = halt_pending | Halt;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      PC           <= '0;
      IR           <= '0;
      DIN          <= '0;
      MemAddr      <= '0;
      MemRd        <= 1'b0;
      Run          <= 1'b0;
      Busy         <= 1'b0;
      Error        <= 1'b0;
      halt_pending <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      MemRd <= 1'b0;
      Run   <= 1'b0;
      if (Halt && Busy)
        halt_pending <= 1'b1;

      case (state)
        S_IDLE, S_ERR: begin
          if (Start) begin
            PC           <= StartAddr;
            MemAddr      <= StartAddr;
            MemRd        <= 1'b1;
            halt_pending <= 1'b0;
            Busy         <= 1'b1;
            Error        <= 1'b0;
            state        <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          case (MemData[8:6])
            OP_HALT: begin
              Busy         <= 1'b0;
              halt_pending <= 1'b0;
              state        <= S_IDLE;
            end
            OP_MV, OP_ADD, OP_SUB: begin
              IR    <= MemData;
              Run   <= 1'b1;
              state <= S_ISSUE;
            end
            OP_MVI: begin
              IR      <= MemData;
              MemAddr <= PC + ADDR_W'(1);
              MemRd   <= 1'b1;
              state   <= S_FETCH_IMM;
            end
            default: begin
              Busy  <= 1'b0;
              Error <= 1'b1;
              state <= S_ERR;
            end
          endcase
        end

        S_FETCH_IMM: state <= S_LOAD_IMM;

        S_LOAD_IMM: begin
          DIN   <= MemData;
          Run   <= 1'b1;
          state <= S_ISSUE;
        end

        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT_DONE;
        end

        // Done takes priority over the timeout on the final allowed cycle.
        S_WAIT_DONE: begin
          if (Done) begin
            PC <= next_pc;
            if (halt_now) begin
              halt_pending <= 1'b0;
              Busy         <= 1'b0;
              state        <= S_IDLE;
            end else begin
              MemAddr <= next_pc;
              MemRd   <= 1'b1;
              state   <= S_FETCH;
            end
          end else if (wait_cnt == CNT_LAST) begin
            Busy  <= 1'b0;
            Error <= 1'b1;
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: program memory model plus a Done responder, a table of
// short programs checked on completion, and hand sequences for reset/halt/timeout.
module tb_instr_sequencer;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              Resetn;
  logic              Start;
  logic [ADDR_W-1:0] StartAddr;
  logic              Halt;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRd;
  logic [8:0]        MemData;
  logic [8:0]        IR;
  logic [8:0]        DIN;
  logic              Run;
  logic              Done;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Error;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(ADDR_W), .DONE_TIMEOUT(15)) dut (
    .clk      (clk),
    .Resetn   (Resetn),
    .Start    (Start),
    .StartAddr(StartAddr),
    .Halt     (Halt),
    .MemAddr  (MemAddr),
    .MemRd    (MemRd),
    .MemData  (MemData),
    .IR       (IR),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .PC       (PC),
    .Busy     (Busy),
    .Error    (Error)
  );

  logic [8:0] mem [0:31];
  always @(posedge clk)
    if (MemRd) MemData <= mem[MemAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every Run pulse and every memory read address.
  int run_cycs[$];
  int run_irs[$];
  int run_dins[$];
  int rd_addrs[$];
  always @(negedge clk) begin
    if (Resetn && Run) begin
      run_cycs.push_back(cyc);
      run_irs.push_back(int'(IR));
      run_dins.push_back(int'(DIN));
    end
    if (Resetn && MemRd) rd_addrs.push_back(int'(MemAddr));
  end

  // Control-unit stand-in: raises Done done_delay cycles after seeing Run.
  bit auto_done;
  int done_delay;
  int done_cnt;
  initial begin
    Done     = 1'b0;
    done_cnt = 0;
    forever begin
      @(negedge clk);
      Done = 1'b0;
      if (!Resetn) done_cnt = 0;
      else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) Done = 1'b1;
        end
        if (Run && auto_done) done_cnt = done_delay;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    Resetn = 1'b0;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 32; i++) mem[i] = 9'o700;
  endtask

  task automatic pulseStart(input logic [ADDR_W-1:0] addr, output int start_cyc);
    Start     = 1'b1;
    StartAddr = addr;
    start_cyc = cyc;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!Busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitRun(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (Run) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [4:0] start_addr;
    logic [8:0] w0, w1, w2;
    int         delay;
    logic [8:0] exp_ir;
    logic [8:0] exp_din;
    logic [4:0] exp_pc;
    int         exp_runs;
    int         exp_lat;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [4:0] a;
    int  base_run, start_cyc;
    bit  ok;
    doReset();
    clearMem();
    a = v.start_addr;      mem[a] = v.w0;
    a = a + 5'd1;          mem[a] = v.w1;
    a = a + 5'd1;          mem[a] = v.w2;
    auto_done  = 1'b1;
    done_delay = v.delay;
    base_run   = run_cycs.size();
    pulseStart(v.start_addr, start_cyc);
    waitIdle(ok);
    checkOutput($sformatf("v%0d_finish", idx), int'(ok), 1);
    checkOutput($sformatf("v%0d_error", idx), int'(Error), int'(v.exp_err));
    checkOutput($sformatf("v%0d_ir", idx), int'(IR), int'(v.exp_ir));
    checkOutput($sformatf("v%0d_din", idx), int'(DIN), int'(v.exp_din));
    checkOutput($sformatf("v%0d_pc", idx), int'(PC), int'(v.exp_pc));
    checkOutput($sformatf("v%0d_runs", idx), run_cycs.size() - base_run, v.exp_runs);
    if (v.exp_runs > 0)
      checkOutput($sformatf("v%0d_latency", idx),
                  (run_cycs.size() > base_run) ? run_cycs[base_run] - start_cyc : -1,
                  v.exp_lat);
  endtask

  initial begin
    bit ok;
    int base_run, base_rd, start_cyc, n;

    vecs[0] = '{5'd0,  9'o012, 9'o201, 9'o700, 2,  9'o201, 9'h000, 5'd2,  2, 3, 1'b0};
    vecs[1] = '{5'd4,  9'o130, 9'h0A5, 9'o700, 2,  9'o130, 9'h0A5, 5'd6,  1, 5, 1'b0};
    vecs[2] = '{5'd10, 9'o312, 9'o700, 9'o700, 1,  9'o312, 9'h000, 5'd11, 1, 3, 1'b0};
    vecs[3] = '{5'd0,  9'o400, 9'o700, 9'o700, 2,  9'o000, 9'h000, 5'd0,  0, 0, 1'b1};
    vecs[4] = '{5'd7,  9'o245, 9'o523, 9'o700, 3,  9'o245, 9'h000, 5'd8,  1, 3, 1'b1};
    vecs[5] = '{5'd31, 9'o155, 9'h1C3, 9'o700, 4,  9'o155, 9'h1C3, 5'd1,  1, 5, 1'b0};
    vecs[6] = '{5'd3,  9'o777, 9'o012, 9'o700, 2,  9'o000, 9'h000, 5'd3,  0, 0, 1'b0};
    vecs[7] = '{5'd12, 9'o612, 9'o700, 9'o700, 2,  9'o000, 9'h000, 5'd12, 0, 0, 1'b1};
    vecs[8] = '{5'd20, 9'o120, 9'o777, 9'o034, 15, 9'o034, 9'o777, 5'd23, 2, 5, 1'b0};

    Resetn = 1'b0; Start = 1'b0; StartAddr = '0; Halt = 1'b0;
    auto_done = 1'b1; done_delay = 2;
    clearMem();

    doReset();
    checkOutput("rst_busy", int'(Busy), 0);
    checkOutput("rst_error", int'(Error), 0);
    checkOutput("rst_memrd", int'(MemRd), 0);
    checkOutput("rst_pc", int'(PC), 0);
    checkOutput("rst_ir", int'(IR), 0);

    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

    // mvi: read addresses and operands presented at the Run pulse
    doReset(); clearMem();
    mem[4] = 9'o130; mem[5] = 9'h0A5;
    auto_done = 1'b1; done_delay = 2;
    base_run = run_cycs.size(); base_rd = rd_addrs.size();
    pulseStart(5'd4, start_cyc);
    waitIdle(ok);
    checkOutput("mvi_rd_count", rd_addrs.size() - base_rd, 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("mvi_rd%0d", i),
                  (rd_addrs.size() > base_rd + i) ? rd_addrs[base_rd + i] : -1, 4 + i);
    checkOutput("mvi_run_ir", (run_irs.size() > base_run) ? run_irs[base_run] : -1, 9'o130);
    checkOutput("mvi_run_din", (run_dins.size() > base_run) ? run_dins[base_run] : -1, 9'h0A5);

    // async reset in the middle of WAIT_DONE
    doReset(); clearMem();
    mem[5] = 9'o012;
    auto_done = 1'b0;
    pulseStart(5'd5, start_cyc);
    waitRun(ok);
    checkOutput("rstmid_run_seen", int'(ok), 1);
    @(negedge clk);
    checkOutput("rstmid_busy_before", int'(Busy), 1);
    #2 Resetn = 1'b0;
    #1;
    checkOutput("rstmid_run", int'(Run), 0);
    checkOutput("rstmid_busy", int'(Busy), 0);
    checkOutput("rstmid_pc", int'(PC), 0);
    checkOutput("rstmid_ir", int'(IR), 0);
    @(negedge clk);
    Resetn = 1'b1;
    base_rd = rd_addrs.size();
    repeat (5) @(negedge clk);
    checkOutput("rstmid_no_read", rd_addrs.size() - base_rd, 0);
    checkOutput("rstmid_idle", int'(Busy), 0);

    // Halt during WAIT_DONE; a Start while busy is also ignored
    doReset(); clearMem();
    mem[0] = 9'o012; mem[1] = 9'o201;
    auto_done = 1'b1; done_delay = 4;
    base_run = run_cycs.size(); base_rd = rd_addrs.size();
    pulseStart(5'd0, start_cyc);
    waitRun(ok);
    @(negedge clk);
    Halt = 1'b1; Start = 1'b1; StartAddr = 5'd9;
    @(negedge clk);
    Halt = 1'b0; Start = 1'b0;
    waitIdle(ok);
    checkOutput("halt_finish", int'(ok), 1);
    checkOutput("halt_pc", int'(PC), 1);
    checkOutput("halt_runs", run_cycs.size() - base_run, 1);
    checkOutput("halt_reads", rd_addrs.size() - base_rd, 1);
    checkOutput("halt_error", int'(Error), 0);

    // Done timeout, sticky error, restart
    doReset(); clearMem();
    mem[0] = 9'o012;
    auto_done = 1'b0;
    pulseStart(5'd0, start_cyc);
    waitRun(ok);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Error) break;
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_cycles", n, 15);
    checkOutput("tmo_busy", int'(Busy), 0);
    checkOutput("tmo_pc", int'(PC), 0);
    Halt = 1'b1;
    repeat (3) @(negedge clk);
    Halt = 1'b0;
    checkOutput("tmo_sticky", int'(Error), 1);
    auto_done = 1'b1; done_delay = 2;
    pulseStart(5'd0, start_cyc);
    checkOutput("tmo_clear_error", int'(Error), 0);
    checkOutput("tmo_restart_busy", int'(Busy), 1);
    waitIdle(ok);
    checkOutput("tmo_restart_pc", int'(PC), 1);
    checkOutput("tmo_restart_error", int'(Error), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/issue scheduler in front of the processor control unit.
- Reads 9-bit instruction words from a synchronous program memory and loads IR, plus DIN for mvi.
- Pulses Run and waits for Done, then advances the program counter; repeats until a HALT word, a Halt request or an error.
- Turns the single-instruction control unit into a free-running program executor.

Parameters:
- ADDR_W, 5: program memory address width; PC wraps modulo 2^ADDR_W.
- DONE_TIMEOUT, 15: max cycles in WAIT_DONE without Done before ERR.

Ports:
- clk  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  begin execution at StartAddr; sampled in IDLE or ERR only.
- StartAddr  in  ADDR_W  first instruction address.
- Halt  in  1  request stop at next instruction boundary.
- MemAddr  out  ADDR_W  program memory address.
- MemRd  out  1  read strobe; MemData valid the cycle after.
- MemData  in  9  program memory read data.
- IR  out  9  instruction to control unit, {opcode[8:6], rx[5:3], ry[2:0]}.
- DIN  out  9  immediate operand for mvi.
- Run  out  1  one-cycle issue pulse to control unit.
- Done  in  1  control unit completion.
- PC  out  ADDR_W  current instruction address.
- Busy  out  1  high in all states except IDLE and ERR.
- Error  out  1  high in ERR.

Behaviour:
- Reset (async, Resetn=0): state=IDLE; PC, IR, DIN, MemAddr = 0; MemRd, Run, Busy, Error = 0; halt_pending=0. Takes effect immediately, including mid-instruction.
- All outputs are registered.
- Opcodes:
  - 0 = mv, 2 = add, 3 = sub: single word.
  - 1 = mvi: two words, the immediate is at PC+1.
  - 7 = HALT: consumed by the sequencer, never issued.
  - 4, 5, 6: illegal.
- IDLE:
  - Start=1 → PC<=StartAddr, halt_pending<=0, go FETCH.
  - Halt is ignored in IDLE; Start wins if Start and Halt arrive together.
- FETCH: MemRd=1, MemAddr=PC for one cycle → DECODE.
- DECODE: capture MemData.
  - Opcode 7 → IDLE; PC holds the HALT address; IR unchanged.
  - Illegal opcode → ERR.
  - Opcode 1 → IR<=MemData, go FETCH_IMM.
  - Otherwise → IR<=MemData, go ISSUE.
- FETCH_IMM: MemRd=1, MemAddr=PC+1 (wraps) → LOAD_IMM.
- LOAD_IMM: DIN<=MemData → ISSUE.
- ISSUE: Run=1 for exactly one cycle; IR and DIN stable from this cycle until the next DECODE → WAIT_DONE.
- WAIT_DONE:
  - Cycle counter cleared on entry; Done is sampled only here, never in ISSUE.
  - Done=1 → PC <= PC+1, or PC+2 for mvi, modulo 2^ADDR_W. Then go IDLE if halt_pending (clearing it), else FETCH.
  - Counter reaches DONE_TIMEOUT with Done=0 → ERR; PC unchanged.
- ERR:
  - Error=1, Busy=0, sticky.
  - Start → clears Error, then behaves as IDLE+Start; Halt is ignored.
- Halt while Busy sets halt_pending; the current instruction always completes. Halt during FETCH/DECODE still lets the fetched instruction issue.
- Start while Busy: ignored.
- Latency, no stalls: single-word instruction = 3 cycles + Done latency; mvi = 5 cycles + Done latency.

Test Plan:
- Reset: assert Resetn=0 during WAIT_DONE → same-cycle Run=0, Busy=0, PC=0, IR=0; after release, state IDLE and no MemRd until Start.
- Program: mem[0]=9'o012 (mv r1,r2), mem[1]=9'o201 (add r0,r1), mem[2]=9'o700 (HALT); Start with StartAddr=0; bench pulses Done 2 cycles after Run → IR=0o012 then 0o201, exactly 2 Run pulses, final PC=2, Busy falls after DECODE of 0o700.
- mvi: mem[4]=9'o130, mem[5]=9'h0A5, mem[6]=HALT; StartAddr=4 → IR=0o130 and DIN=0x0A5 held at the Run pulse, MemAddr sequence 4,5,6, final PC=6.
- Halt: assert Halt for 1 cycle during WAIT_DONE of the instruction at 0 → instruction completes, PC=1, IDLE, no MemRd to address 1.
- Timeout/illegal: Done never asserted → Error=1 exactly 15 cycles after entering WAIT_DONE, Busy=0, then Start clears it. Separately, mem[0]=9'o400 → Error=1 with no Run pulse.
- Wrap: mvi at address 31 with immediate at mem[0] (ADDR_W=5) → DIN=mem[0], PC becomes 1 after Done.
